// File: rtl/wb_arbiter_pkg.sv
// Shared widths, writeback request payloads and requester index map for the
// writeback arbiter.
package wb_arbiter_pkg;

    localparam int WORD_W = 32;
    localparam int REG_W  = 5;
    localparam int MAT_W  = 4;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [REG_W-1:0]  regbits_t;
    typedef logic [MAT_W-1:0]  matbits_t;

    typedef struct packed {
        regbits_t rd;
        word_t    data;
    } wb_s_req_t;

    typedef struct packed {
        matbits_t rd;
    } wb_m_req_t;

    // Requester slots follow the fu_scalar_t / fu_matrix_t ordering.
    localparam int WB_S_ALU  = 0;
    localparam int WB_S_LDST = 0 + 1;
    localparam int WB_M_LDST = 0;
    localparam int WB_M_GEMM = 1;

endpackage

// File: rtl/wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from rr_ptr with wrap; the
// pointer moves to the slot after the winner whenever a grant is issued.
module wb_arbiter_rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] grant
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] ptr_nxt;

    always_comb begin
        int  idx;
        logic found;
        idx     = 0;
        found   = 1'b0;
        grant   = '0;
        ptr_nxt = rr_ptr;
        if (en) begin
            for (int k = 0; k < N; k++) begin
                idx = int'(rr_ptr) + k;
                if (idx >= N) idx = idx - N;
                // Inner loop keeps every index a constant after unrolling.
                for (int i = 0; i < N; i++) begin
                    if (i == idx && req[i] && !found) begin
                        grant[i] = 1'b1;
                        found    = 1'b1;
                        ptr_nxt  = (i == N - 1) ? '0 : PTR_W'(i + 1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_ptr <= '0;
        else        rr_ptr <= ptr_nxt;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: scalar and matrix lanes, each with one-entry holding
// buffers per requester, round-robin grant and registered write/done outputs.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int N_SREQ = 2,
    parameter int N_MREQ = 2
) (
    input  logic                         CLK,
    input  logic                         nRST,
    input  logic [N_SREQ-1:0]            s_req_valid,
    output logic [N_SREQ-1:0]            s_req_ready,
    input  logic [N_SREQ-1:0][REG_W-1:0] s_req_rd,
    input  logic [N_SREQ-1:0][WORD_W-1:0] s_req_data,
    input  logic [N_MREQ-1:0]            m_req_valid,
    output logic [N_MREQ-1:0]            m_req_ready,
    input  logic [N_MREQ-1:0][MAT_W-1:0] m_req_rd,
    input  logic                         s_wb_stall,
    input  logic                         m_wb_stall,
    output logic                         s_wen,
    output logic [REG_W-1:0]             s_waddr,
    output logic [WORD_W-1:0]            s_wdata,
    output logic [N_SREQ-1:0]            s_done,
    output logic                         m_wen,
    output logic [MAT_W-1:0]             m_waddr,
    output logic [N_MREQ-1:0]            m_done
);

    // ---------------- scalar lane ----------------
    logic      [N_SREQ-1:0] s_hold_v;
    wb_s_req_t [N_SREQ-1:0] s_hold_q;
    logic      [N_SREQ-1:0] s_grant;
    logic      [N_SREQ-1:0] s_load;
    wb_s_req_t              s_sel;

    // A granted buffer frees this cycle, so it can take a new result at once.
    assign s_req_ready = ~s_hold_v | s_grant;
    assign s_load      = s_req_valid & s_req_ready;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            s_hold_v <= '0;
            s_hold_q <= '0;
        end else begin
            for (int i = 0; i < N_SREQ; i++) begin
                if (s_load[i]) begin
                    s_hold_v[i]      <= 1'b1;
                    s_hold_q[i].rd   <= s_req_rd[i];
                    s_hold_q[i].data <= s_req_data[i];
                end else if (s_grant[i]) begin
                    s_hold_v[i] <= 1'b0;
                end
            end
        end
    end

    wb_arbiter_rr_arbiter #(.N(N_SREQ)) u_s_arb (
        .clk   (CLK),
        .rst_n (nRST),
        .req   (s_hold_v),
        .en    (!s_wb_stall),
        .grant (s_grant)
    );

    always_comb begin
        s_sel = '0;
        for (int i = 0; i < N_SREQ; i++)
            if (s_grant[i]) s_sel = s_sel | s_hold_q[i];
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            s_wen   <= 1'b0;
            s_waddr <= '0;
            s_wdata <= '0;
            s_done  <= '0;
        end else if (|s_grant) begin
            // x0 is hardwired zero: retire the FU but suppress the write.
            s_wen   <= (s_sel.rd != '0);
            s_waddr <= s_sel.rd;
            s_wdata <= s_sel.data;
            s_done  <= s_grant;
        end else begin
            s_wen  <= 1'b0;
            s_done <= '0;
        end
    end

    // ---------------- matrix lane ----------------
    logic      [N_MREQ-1:0] m_hold_v;
    wb_m_req_t [N_MREQ-1:0] m_hold_q;
    logic      [N_MREQ-1:0] m_grant;
    logic      [N_MREQ-1:0] m_load;
    wb_m_req_t              m_sel;

    assign m_req_ready = ~m_hold_v | m_grant;
    assign m_load      = m_req_valid & m_req_ready;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m_hold_v <= '0;
            m_hold_q <= '0;
        end else begin
            for (int i = 0; i < N_MREQ; i++) begin
                if (m_load[i]) begin
                    m_hold_v[i]    <= 1'b1;
                    m_hold_q[i].rd <= m_req_rd[i];
                end else if (m_grant[i]) begin
                    m_hold_v[i] <= 1'b0;
                end
            end
        end
    end

    wb_arbiter_rr_arbiter #(.N(N_MREQ)) u_m_arb (
        .clk   (CLK),
        .rst_n (nRST),
        .req   (m_hold_v),
        .en    (!m_wb_stall),
        .grant (m_grant)
    );

    always_comb begin
        m_sel = '0;
        for (int i = 0; i < N_MREQ; i++)
            if (m_grant[i]) m_sel = m_sel | m_hold_q[i];
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m_wen   <= 1'b0;
            m_waddr <= '0;
            m_done  <= '0;
        end else if (|m_grant) begin
            m_wen   <= 1'b1;
            m_waddr <= m_sel.rd;
            m_done  <= m_grant;
        end else begin
            m_wen  <= 1'b0;
            m_done <= '0;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, single, contention, stall, x0,
// parallel lanes and back-to-back streaming.
module tb_wb_arbiter;

    logic             CLK = 1'b0;
    logic             nRST;
    logic [1:0]       s_req_valid;
    logic [1:0]       s_req_ready;
    logic [1:0][4:0]  s_req_rd;
    logic [1:0][31:0] s_req_data;
    logic [1:0]       m_req_valid;
    logic [1:0]       m_req_ready;
    logic [1:0][3:0]  m_req_rd;
    logic             s_wb_stall;
    logic             m_wb_stall;
    logic             s_wen;
    logic [4:0]       s_waddr;
    logic [31:0]      s_wdata;
    logic [1:0]       s_done;
    logic             m_wen;
    logic [3:0]       m_waddr;
    logic [1:0]       m_done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    wb_arbiter dut (
        .CLK(CLK), .nRST(nRST),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
        .s_req_rd(s_req_rd), .s_req_data(s_req_data),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
        .m_req_rd(m_req_rd),
        .s_wb_stall(s_wb_stall), .m_wb_stall(m_wb_stall),
        .s_wen(s_wen), .s_waddr(s_waddr), .s_wdata(s_wdata), .s_done(s_done),
        .m_wen(m_wen), .m_waddr(m_waddr), .m_done(m_done)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        s_req_valid = '0; s_req_rd = '0; s_req_data = '0;
        m_req_valid = '0; m_req_rd = '0;
        s_wb_stall = 1'b0; m_wb_stall = 1'b0;
        tick(); tick();
        n_tests++;
        if ({s_wen, s_done, m_wen, m_done} !== 6'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 000000", {s_wen, s_done, m_wen, m_done});
        end
        n_tests++;
        if ({s_waddr, s_wdata, m_waddr} !== 41'b0) begin
            n_fail++; $display("FAIL reset_data: got %h/%h/%h want 0", s_waddr, s_wdata, m_waddr);
        end
        n_tests++;
        if ({s_req_ready, m_req_ready} !== 4'b1111) begin
            n_fail++; $display("FAIL reset_ready: got %b want 1111", {s_req_ready, m_req_ready});
        end
        nRST = 1'b1;
        tick();
    endtask

    task automatic test_single();
        s_req_valid = 2'b01; s_req_rd[0] = 5'd5; s_req_data[0] = 32'hDEADBEEF;
        tick();
        s_req_valid = 2'b00;
        n_tests++;
        if (s_wen !== 1'b0) begin
            n_fail++; $display("FAIL single_early: s_wen got %b want 0", s_wen);
        end
        tick();
        n_tests++;
        if ({s_wen, s_waddr, s_wdata, s_done} !== {1'b1, 5'd5, 32'hDEADBEEF, 2'b01}) begin
            n_fail++; $display("FAIL single_wb: got wen=%b addr=%0d data=%h done=%b want 1/5/deadbeef/01",
                               s_wen, s_waddr, s_wdata, s_done);
        end
        tick();
        n_tests++;
        if ({s_wen, s_done, s_waddr} !== {1'b0, 2'b00, 5'd5}) begin
            n_fail++; $display("FAIL single_once: got wen=%b done=%b addr=%0d want 0/00/5", s_wen, s_done, s_waddr);
        end
    endtask

    task automatic test_reset_mid();
        // Pointer is 1 after the single ALU grant; reset must clear it.
        s_req_valid = 2'b01; s_req_rd[0] = 5'd3; s_req_data[0] = 32'h11;
        tick();
        s_req_valid = 2'b00;
        nRST = 1'b0;
        #1;
        tick();
        n_tests++;
        if ({s_wen, s_done} !== 3'b000) begin
            n_fail++; $display("FAIL rstmid_nowb: got wen=%b done=%b want 0/00", s_wen, s_done);
        end
        nRST = 1'b1;
        tick();
        n_tests++;
        if ({s_wen, s_done} !== 3'b000) begin
            n_fail++; $display("FAIL rstmid_after: got wen=%b done=%b want 0/00", s_wen, s_done);
        end
        n_tests++;
        if (s_req_ready !== 2'b11) begin
            n_fail++; $display("FAIL rstmid_ready: got %b want 11", s_req_ready);
        end
        n_tests++;
        if (dut.u_s_arb.rr_ptr !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_ptr: got %0d want 0", dut.u_s_arb.rr_ptr);
        end
    endtask

    task automatic test_contention();
        logic [4:0] exp_addr [5];
        logic [1:0] exp_done [5];
        exp_addr = '{5'd1, 5'd2, 5'd1, 5'd2, 5'd1};
        exp_done = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
        s_req_valid = 2'b11;
        s_req_rd[0] = 5'd1; s_req_data[0] = 32'hA1;
        s_req_rd[1] = 5'd2; s_req_data[1] = 32'hB2;
        tick();
        n_tests++;
        if (s_req_ready !== 2'b01) begin
            n_fail++; $display("FAIL rr_ready0: got %b want 01", s_req_ready);
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            if (c == 2) s_req_valid = 2'b00;
            n_tests++;
            if ({s_wen, s_waddr, s_done} !== {1'b1, exp_addr[c], exp_done[c]}) begin
                n_fail++; $display("FAIL rr_seq%0d: got wen=%b addr=%0d done=%b want 1/%0d/%b",
                                   c, s_wen, s_waddr, s_done, exp_addr[c], exp_done[c]);
            end
            if (c == 0 || c == 1) begin
                n_tests++;
                if (s_req_ready !== ((c == 0) ? 2'b10 : 2'b01)) begin
                    n_fail++; $display("FAIL rr_ready%0d: got %b want %b", c + 1, s_req_ready,
                                       (c == 0) ? 2'b10 : 2'b01);
                end
            end
        end
        tick();
        n_tests++;
        if (s_wen !== 1'b0) begin
            n_fail++; $display("FAIL rr_drain: s_wen got %b want 0", s_wen);
        end
    endtask

    task automatic test_stall();
        // Last contention grant was the ALU, so the pointer sits at 1.
        s_req_valid = 2'b01; s_req_rd[0] = 5'd7; s_req_data[0] = 32'h77;
        tick();
        s_req_valid = 2'b00;
        s_wb_stall  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_tests++;
            if (s_req_ready[0] !== 1'b0) begin
                n_fail++; $display("FAIL stall_ready%0d: got %b want 0", c, s_req_ready[0]);
            end
            tick();
            n_tests++;
            if (s_wen !== 1'b0 || s_done !== 2'b00 || dut.u_s_arb.rr_ptr !== 1'b1) begin
                n_fail++; $display("FAIL stall_hold%0d: got wen=%b done=%b ptr=%0d want 0/00/1",
                                   c, s_wen, s_done, dut.u_s_arb.rr_ptr);
            end
        end
        s_wb_stall = 1'b0;
        tick();
        n_tests++;
        if ({s_wen, s_waddr, s_wdata, s_done} !== {1'b1, 5'd7, 32'h77, 2'b01}) begin
            n_fail++; $display("FAIL stall_release: got wen=%b addr=%0d data=%h done=%b want 1/7/77/01",
                               s_wen, s_waddr, s_wdata, s_done);
        end
    endtask

    task automatic test_x0();
        s_req_valid = 2'b10; s_req_rd[1] = 5'd0; s_req_data[1] = 32'h5;
        tick();
        s_req_valid = 2'b00;
        tick();
        n_tests++;
        if ({s_wen, s_done} !== 3'b010) begin
            n_fail++; $display("FAIL x0_drop: got wen=%b done=%b want 0/10", s_wen, s_done);
        end
        tick();
    endtask

    task automatic test_parallel_b2b();
        // Both pointers sit at 0 here.
        m_req_valid = 2'b11; m_req_rd[0] = 4'd9; m_req_rd[1] = 4'd4;
        s_req_valid = 2'b01; s_req_rd[0] = 5'd1; s_req_data[0] = 32'h101;
        tick();
        m_req_valid = 2'b00;
        for (int c = 0; c < 4; c++) begin
            if (c < 3) begin
                s_req_rd[0]   = 5'(c + 2);
                s_req_data[0] = 32'h101 + 32'(c + 1);
            end else begin
                s_req_valid = 2'b00;
            end
            tick();
            n_tests++;
            if ({s_wen, s_waddr, s_wdata} !== {1'b1, 5'(c + 1), 32'h101 + 32'(c)}) begin
                n_fail++; $display("FAIL b2b_s%0d: got wen=%b addr=%0d data=%h want 1/%0d/%h",
                                   c, s_wen, s_waddr, s_wdata, c + 1, 32'h101 + 32'(c));
            end
            if (c == 0) begin
                n_tests++;
                if ({m_wen, m_waddr, m_done} !== {1'b1, 4'd9, 2'b01}) begin
                    n_fail++; $display("FAIL par_m0: got wen=%b addr=%0d done=%b want 1/9/01", m_wen, m_waddr, m_done);
                end
            end else if (c == 1) begin
                n_tests++;
                if ({m_wen, m_waddr, m_done} !== {1'b1, 4'd4, 2'b10}) begin
                    n_fail++; $display("FAIL par_m1: got wen=%b addr=%0d done=%b want 1/4/10", m_wen, m_waddr, m_done);
                end
            end else if (c == 2) begin
                n_tests++;
                if (m_wen !== 1'b0) begin
                    n_fail++; $display("FAIL par_m2: m_wen got %b want 0", m_wen);
                end
            end
        end
        tick();
        n_tests++;
        if (s_wen !== 1'b0) begin
            n_fail++; $display("FAIL b2b_end: s_wen got %b want 0", s_wen);
        end
    endtask

    task automatic test_m_reg0();
        m_req_valid = 2'b10; m_req_rd[1] = 4'd0;
        tick();
        m_req_valid = 2'b00;
        tick();
        n_tests++;
        if ({m_wen, m_waddr, m_done} !== {1'b1, 4'd0, 2'b10}) begin
            n_fail++; $display("FAIL m_reg0: got wen=%b addr=%0d done=%b want 1/0/10", m_wen, m_waddr, m_done);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_reset_mid();
        test_contention();
        test_stall();
        test_x0();
        test_parallel_b2b();
        test_m_reg0();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
